// File: rtl/disaggregator_pkg.sv
// Shared helpers for the aggregator/disaggregator width-conversion pair:
// lane-counter sizing and the fetch-width clamp.
package disaggregator_pkg;

  function automatic int lane_cnt_width(input int fetch_width);
    return $clog2(fetch_width) + 1;
  endfunction

  // Out-of-range requests (0 or above the maximum) fall back to the full width
  function automatic int clamp_fetch_width(input int req, input int fetch_width);
    int res;
    if ((req == 0) || (req > fetch_width)) begin
      res = fetch_width;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/disaggregator_fetch_width_ctrl.sv
// Runtime fetch-width controller shared by the aggregator and disaggregator.
// Holds the active width plus a pending request deferred until the word in flight completes.
module fetch_width_ctrl
  import disaggregator_pkg::*;
#(
  parameter int FETCH_WIDTH = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     change_fetch_width,
  input  logic [lane_cnt_width(FETCH_WIDTH)-1:0]   input_fetch_width,
  input  logic                                     word_done,
  output logic [lane_cnt_width(FETCH_WIDTH)-1:0]   fetch_width
);

  localparam int CW = lane_cnt_width(FETCH_WIDTH);

  logic [CW-1:0] active_r;
  logic [CW-1:0] pending_width_r;
  logic          pending_r;
  logic [CW-1:0] req_s;

  assign req_s = CW'(clamp_fetch_width(int'(input_fetch_width), FETCH_WIDTH));

  // A pending width becomes effective for a load that coincides with the word completing
  assign fetch_width = pending_r ? pending_width_r : active_r;

  // Active/pending width registers; latest request always wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r        <= CW'(FETCH_WIDTH);
      pending_width_r <= {CW{1'b0}};
      pending_r       <= 1'b0;
    end else if (change_fetch_width && word_done) begin
      active_r  <= req_s;
      pending_r <= 1'b0;
    end else if (change_fetch_width) begin
      pending_r       <= 1'b1;
      pending_width_r <= req_s;
    end else if (pending_r && word_done) begin
      active_r  <= pending_width_r;
      pending_r <= 1'b0;
    end else begin
      active_r        <= active_r;
      pending_width_r <= pending_width_r;
      pending_r       <= pending_r;
    end
  end

endmodule

// File: rtl/disaggregator.sv
// Wide-to-narrow splitter: pops FETCH_WIDTH-lane words and emits lanes LSB-first.
// Optional macro DISAGGREGATOR_LAST_EN adds a receiver_last output marking each word's final lane.
module disaggregator
  import disaggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]      sender_data,
  input  logic                                   sender_empty_n,
  output logic                                   sender_deq,
  output logic [DATA_WIDTH-1:0]                  receiver_data,
  input  logic                                   receiver_full_n,
  output logic                                   receiver_enq,
`ifdef DISAGGREGATOR_LAST_EN
  output logic                                   receiver_last,
`endif
  input  logic                                   change_fetch_width,
  input  logic [lane_cnt_width(FETCH_WIDTH)-1:0] input_fetch_width
);

  localparam int CW = lane_cnt_width(FETCH_WIDTH);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sr_r;
  logic                              valid_r;
  logic [CW-1:0]                     lane_cnt_r;
  logic [CW-1:0]                     fetch_width_s;
  logic                              last_s;
  logic                              word_done_s;
  logic                              deq_s;
  logic                              enq_s;

  assign last_s      = valid_r && (lane_cnt_r == CW'(1));
  assign word_done_s = !valid_r || (last_s && receiver_full_n);
  assign enq_s       = rst_n && valid_r && receiver_full_n;
  assign deq_s       = rst_n && sender_empty_n && word_done_s;

  assign sender_deq    = deq_s;
  assign receiver_enq  = enq_s;
  assign receiver_data = sr_r[DATA_WIDTH-1:0];
`ifdef DISAGGREGATOR_LAST_EN
  assign receiver_last = last_s;
`endif

  fetch_width_ctrl #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_fetch_width_ctrl (
    .clk                (clk),
    .rst_n              (rst_n),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width),
    .word_done          (word_done_s),
    .fetch_width        (fetch_width_s)
  );

  // Word load has priority over the shift; SR is cleared when a word drains so idle data reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r       <= {(FETCH_WIDTH*DATA_WIDTH){1'b0}};
      valid_r    <= 1'b0;
      lane_cnt_r <= {CW{1'b0}};
    end else if (deq_s) begin
      sr_r       <= sender_data;
      valid_r    <= 1'b1;
      lane_cnt_r <= fetch_width_s;
    end else if (enq_s) begin
      if (last_s) begin
        sr_r       <= {(FETCH_WIDTH*DATA_WIDTH){1'b0}};
        valid_r    <= 1'b0;
        lane_cnt_r <= {CW{1'b0}};
      end else begin
        sr_r       <= sr_r >> DATA_WIDTH;
        valid_r    <= valid_r;
        lane_cnt_r <= lane_cnt_r - CW'(1);
      end
    end else begin
      sr_r       <= sr_r;
      valid_r    <= valid_r;
      lane_cnt_r <= lane_cnt_r;
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Directed, table-driven bench for disaggregator (DATA_WIDTH=8, FETCH_WIDTH=2),
// plus hand-written reset-mid-word and random-backpressure sequences.
module tb_disaggregator;

  logic        clk;
  logic        rst_n;
  logic [15:0] sender_data;
  logic        sender_empty_n;
  logic        sender_deq;
  logic [7:0]  receiver_data;
  logic        receiver_full_n;
  logic        receiver_enq;
  logic        change_fetch_width;
  logic [1:0]  input_fetch_width;
`ifdef DISAGGREGATOR_LAST_EN
  logic        receiver_last;
`endif

  int tests = 0;
  int fails = 0;

  disaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sender_data        (sender_data),
    .sender_empty_n     (sender_empty_n),
    .sender_deq         (sender_deq),
    .receiver_data      (receiver_data),
    .receiver_full_n    (receiver_full_n),
    .receiver_enq       (receiver_enq),
`ifdef DISAGGREGATOR_LAST_EN
    .receiver_last      (receiver_last),
`endif
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic [15:0] sd;
    logic        fn;
    logic        chg;
    logic [1:0]  ifw;
    logic        deq;
    logic        enq;
    logic [7:0]  rd;
    logic        lst;
  } vec_t;

  vec_t vecs [34];

  // Reference FIFO and expected lane stream for the random-backpressure run
  logic [15:0] fifo_q [$];
  logic [7:0]  exp_q  [$];

  initial begin
    int lanes;
    int got;
    logic e_deq;
    logic e_enq;
    logic [7:0] e_byte;

    //            en  sd        fn  chg ifw  deq enq rd     lst
    vecs[0]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 16'h0302, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 16'h0302, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h01, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h02, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h03, 1'b1};
    vecs[5]  = '{1'b1, 16'h0504, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 16'h0706, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 16'h0706, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h04, 1'b0};
    vecs[8]  = '{1'b1, 16'h0706, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 16'h0706, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h05, 1'b1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h06, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h07, 1'b1};
    // width change together with a deq: affects the next word only
    vecs[12] = '{1'b1, 16'h0B0A, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 16'h0D0C, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h0A, 1'b0};
    vecs[14] = '{1'b1, 16'h0D0C, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h0B, 1'b1};
    vecs[15] = '{1'b1, 16'h0F0E, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h0C, 1'b1};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'h0E, 1'b1};
    vecs[17] = '{1'b1, 16'h1110, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h10, 1'b0};
    vecs[19] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[20] = '{1'b1, 16'h1312, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h12, 1'b0};
    vecs[22] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h13, 1'b1};
    // change while lane 0 is in flight: pending, applied to the overlapped next word
    vecs[23] = '{1'b1, 16'h0504, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[24] = '{1'b1, 16'h0706, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 8'h04, 1'b0};
    vecs[25] = '{1'b1, 16'h0706, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h05, 1'b1};
    vecs[26] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 8'h06, 1'b1};
    // two changes while pending: the latest (width 2) wins
    vecs[27] = '{1'b1, 16'h1514, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[28] = '{1'b1, 16'h1716, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[29] = '{1'b1, 16'h1716, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 8'h14, 1'b0};
    vecs[30] = '{1'b1, 16'h1716, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 8'h15, 1'b1};
    vecs[31] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h16, 1'b0};
    vecs[32] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h17, 1'b1};
    vecs[33] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0};

    rst_n              = 1'b0;
    sender_data        = 16'h0000;
    sender_empty_n     = 1'b0;
    receiver_full_n    = 1'b1;
    change_fetch_width = 1'b0;
    input_fetch_width  = 2'd0;

    // Reset state
    #3;
    check("reset_deq", sender_deq, 1'b0);
    check("reset_enq", receiver_enq, 1'b0);
    check("reset_data", receiver_data, 8'h00);
    sender_empty_n = 1'b1;
    sender_data    = 16'hAAAA;
    #1;
    check("reset_no_pop", sender_deq, 1'b0);
`ifdef DISAGGREGATOR_LAST_EN
    check("reset_last", receiver_last, 1'b0);
`endif
    @(negedge clk);
    sender_empty_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle-by-cycle vector table
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      sender_empty_n     = vecs[i].en;
      sender_data        = vecs[i].sd;
      receiver_full_n    = vecs[i].fn;
      change_fetch_width = vecs[i].chg;
      input_fetch_width  = vecs[i].ifw;
      #1;
      check($sformatf("vec%0d_deq", i), sender_deq, vecs[i].deq);
      check($sformatf("vec%0d_enq", i), receiver_enq, vecs[i].enq);
      if (vecs[i].enq) begin
        check($sformatf("vec%0d_data", i), receiver_data, vecs[i].rd);
      end
`ifdef DISAGGREGATOR_LAST_EN
      check($sformatf("vec%0d_last", i), receiver_last, vecs[i].lst);
`endif
    end
    change_fetch_width = 1'b0;

    // Reset mid-word: lane 1 of 0x0908 must be discarded
    @(negedge clk);
    sender_empty_n  = 1'b1;
    sender_data     = 16'h0908;
    receiver_full_n = 1'b1;
    #1 check("rst_mid_deq", sender_deq, 1'b1);
    @(negedge clk);
    sender_data = 16'h0B0A;
    #1;
    check("rst_mid_lane0_enq", receiver_enq, 1'b1);
    check("rst_mid_lane0_data", receiver_data, 8'h08);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_enq_low", receiver_enq, 1'b0);
    check("rst_mid_deq_low", sender_deq, 1'b0);
    check("rst_mid_data_clr", receiver_data, 8'h00);
    @(negedge clk);
    #1;
    check("rst_hold_enq_low", receiver_enq, 1'b0);
    check("rst_hold_deq_low", sender_deq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_deq", sender_deq, 1'b1);
    check("rst_rel_enq", receiver_enq, 1'b0);
    @(negedge clk);
    sender_empty_n = 1'b0;
    #1;
    check("rst_rel_enq0", receiver_enq, 1'b1);
    check("rst_rel_data0", receiver_data, 8'h0A);
    @(negedge clk);
    #1;
    check("rst_rel_data1", receiver_data, 8'h0B);
    @(negedge clk);
    #1;
    check("rst_rel_idle", receiver_enq, 1'b0);

    // Random backpressure and upstream gaps against a lane-count model
    for (int k = 0; k < 16; k++) begin
      fifo_q.push_back({8'(2 * k + 1), 8'(2 * k)});
      exp_q.push_back(8'(2 * k));
      exp_q.push_back(8'(2 * k + 1));
    end
    lanes = 0;
    got   = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ((fifo_q.size() == 0) && (lanes == 0)) break;
      @(negedge clk);
      receiver_full_n = ($urandom_range(0, 2) != 0);
      sender_empty_n  = (fifo_q.size() > 0) && ($urandom_range(0, 3) != 0);
      sender_data     = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
      #1;
      e_enq = (lanes > 0) && receiver_full_n;
      e_deq = sender_empty_n && ((lanes == 0) || ((lanes == 1) && receiver_full_n));
      check($sformatf("rnd%0d_enq", cyc), receiver_enq, e_enq);
      check($sformatf("rnd%0d_deq", cyc), sender_deq, e_deq);
`ifdef DISAGGREGATOR_LAST_EN
      check($sformatf("rnd%0d_last", cyc), receiver_last, lanes == 1);
`endif
      if (receiver_enq) begin
        if (exp_q.size() > 0) begin
          e_byte = exp_q.pop_front();
          check($sformatf("rnd%0d_data", cyc), receiver_data, e_byte);
        end else begin
          check($sformatf("rnd%0d_extra_enq", cyc), receiver_enq, 1'b0);
        end
        got++;
      end
      if (sender_deq) begin
        if (fifo_q.size() > 0) begin
          void'(fifo_q.pop_front());
        end else begin
          check($sformatf("rnd%0d_pop_empty", cyc), sender_deq, 1'b0);
        end
        lanes = 2;
      end else if (receiver_enq) begin
        lanes--;
      end else begin
        lanes = lanes;
      end
    end
    check("rnd_lane_count", got, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disaggregator.md
Name: disaggregator

Overview:
Width-splitting stage, the mirror of the aggregator. Pops one wide word of FETCH_WIDTH lanes from an upstream show-ahead FIFO. Emits the lanes one per cycle, lane 0 (LSBs) first, to a narrow downstream receiver. Runtime fetch width (1..FETCH_WIDTH) uses the same change_fetch_width/input_fetch_width control as the aggregator, so a disaggregator/aggregator pair round-trips data.

Parameters:
DATA_WIDTH, 8, bits per lane / output word
FETCH_WIDTH, 2, max lanes per input word (>=1)

Ports:
clk  input  1  single clock
rst_n  input  1  reset, asynchronous, active-low
sender_data  input  FETCH_WIDTH*DATA_WIDTH  head of upstream FIFO, lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
sender_empty_n  input  1  upstream FIFO has a word
sender_deq  output  1  pop upstream FIFO this cycle
receiver_data  output  DATA_WIDTH  current lane
receiver_full_n  input  1  downstream can accept
receiver_enq  output  1  push receiver_data this cycle
change_fetch_width  input  1  request to load input_fetch_width
input_fetch_width  input  $clog2(FETCH_WIDTH)+1  requested lanes per word

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Reset clears all state. Reset values: valid=0, lane_cnt=0, pending=0, fetch_width=FETCH_WIDTH, shift register=0. With valid=0 the outputs are sender_deq=0, receiver_enq=0, receiver_data=0.
- State: shift register SR (FETCH_WIDTH*DATA_WIDTH), valid flag, lane_cnt (lanes remaining, 0..FETCH_WIDTH), active fetch_width, pending flag, pending_width.
- receiver_data = SR[DATA_WIDTH-1:0], driven from a register.
- receiver_enq = valid && receiver_full_n (combinational).
- last = valid && (lane_cnt == 1).
- sender_deq = sender_empty_n && (!valid || (last && receiver_full_n)) && !rst_n-window. It never asserts while sender_empty_n=0.
- On sender_deq: SR <= sender_data, lane_cnt <= fetch_width, valid <= 1. This takes priority over the shift of the outgoing word.
- On receiver_enq without deq:
  - If lane_cnt==1: valid <= 0, lane_cnt <= 0.
  - Otherwise: SR >>= DATA_WIDTH and lane_cnt decrements.
- Lanes at index >= fetch_width are dropped. They are never emitted.
- Latency: a word at the FIFO head in cycle N (idle block) is popped in N. Lane 0 is enqueued in N+1 at the earliest.
- Throughput: back-to-back words give one lane per cycle with no bubble (deq overlaps the last lane).
- Backpressure: when receiver_full_n=0, SR, lane_cnt and valid all hold; sender_deq stays 0 while valid.
- Fetch width change:
  - When change_fetch_width=1, input_fetch_width is captured. A value of 0 or greater than FETCH_WIDTH clamps to FETCH_WIDTH.
  - If the block is idle (!valid) or its last lane is being enqueued this cycle, the new width applies from the next deq.
  - Otherwise it is stored as pending. It applies at the first cycle where the current word completes, and the word in flight is never altered.
  - A second change while pending overwrites pending_width (latest wins).
  - A change in the same cycle as a deq affects the following word, not the one being loaded.
- Reset mid-word: the partial word is discarded. No enq happens while rst_n=0. Upstream data is not popped during reset.

Optional Feature:
Macro DISAGGREGATOR_LAST_EN.
- Defined: adds output port receiver_last (1 bit), = last. It is asserted with the final emitted lane of each word. Reset value 0.
- Undefined: the port does not exist and there is no extra logic; behaviour is otherwise identical.

Decomposition:
- Shared package (alongside the aggregator's): localparam functions for lane-count width ($clog2(FETCH_WIDTH)+1) and the clamp-to-FETCH_WIDTH function. The aggregator reuses both.
- One natural sub-module: fetch_width_ctrl. It holds the active width, the pending flag and pending_width, with inputs change_fetch_width, input_fetch_width and word_done. It is shareable with the aggregator.

Test Plan:
- DATA_WIDTH=8, FETCH_WIDTH=2, receiver_full_n=1, FIFO holds 0x0100, 0x0302 -> receiver_data 0x00, 0x01, 0x02, 0x03 on four consecutive enq cycles. Deq of the second word coincides with enq of 0x01.
- Same stream with receiver_full_n toggled randomly -> output sequence is unchanged, with no duplicates or drops. sender_deq is never asserted while valid and not last.
- Upstream sender_empty_n random, with a counting source feeding the aggregator, disaggregator and back to the aggregator -> the aggregator output equals the expected counter pairs (0x0100, 0x0302, ...) for 2000 ns.
- change_fetch_width=1 with input_fetch_width=1 while lane 0 of 0x0504 is pending -> 0x04, 0x05 are emitted, then the next word 0x0706 yields only 0x06.
- input_fetch_width=0 or 3 -> clamped to 2; words emit both lanes.
- Assert rst_n=0 after lane 0 of 0x0908 -> receiver_enq=0 immediately. After release, the next enq is lane 0 of the next FIFO word, and 0x09 is never emitted. With DISAGGREGATOR_LAST_EN, receiver_last is high only on odd lanes in the FETCH_WIDTH=2 stream.
